// File: rtl/mem_lsu_if.sv
// mem_lsu_if: word-aligned data-memory beat bus between the load/store unit and memory
interface mem_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ready, mem_rdata);
    modport slave (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit issuing byte-enabled word beats, splitting word-crossing accesses, extending loads
module mem_lsu #(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Store_Type,
    input  logic [2:0]        Load_Type,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              misaligned,
    mem_lsu_if.master         mem
);
    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] a_addr, lo, sh, ext;
    logic [DATA_W-1:0] a_wdata;
    logic [2:0] a_n, in_n;
    logic a_sgn, a_we, a_mis, in_sgn, req, in_cross, a_cross, last, beat, hi_beat;
    logic [3:0] mask;
    logic [7:0] be8;
    logic [63:0] wd64, rd64;

    assign req = MemRead | MemWrite;
    assign in_n = MemWrite ? (Store_Type == 2'b01 ? 3'd2 : Store_Type == 2'b10 ? 3'd1 : 3'd4)
                           : (Load_Type == 3'b001 || Load_Type == 3'b010 ? 3'd2
                            : Load_Type == 3'b011 || Load_Type == 3'b100 ? 3'd1 : 3'd4);
    assign in_sgn = Load_Type == 3'b001 || Load_Type == 3'b011;
    assign in_cross = {1'b0, addr[1:0]} + in_n > 3'd4;
    assign a_cross = {1'b0, a_addr[1:0]} + a_n > 3'd4;
    // Shifting into a double-width window yields both beats' lanes at once: low half is beat 1, high half beat 2.
    assign mask = a_n == 3'd4 ? 4'hF : a_n == 3'd2 ? 4'h3 : 4'h1;
    assign be8 = {4'h0, mask} << a_addr[1:0];
    assign wd64 = {32'h0, a_wdata} << {a_addr[1:0], 3'b000};
    assign rd64 = state == BEAT2 ? {mem.mem_rdata, lo} : {32'h0, mem.mem_rdata};
    assign sh = 32'(rd64 >> {a_addr[1:0], 3'b000});
    assign ext = a_n == 3'd1 ? {{24{a_sgn & sh[7]}}, sh[7:0]}
               : a_n == 3'd2 ? {{16{a_sgn & sh[15]}}, sh[15:0]} : sh;
    assign last = mem.mem_ready && (state == BEAT2 || (state == BEAT1 && !a_cross));

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !req ? IDLE : (in_cross && !ALLOW_MISALIGNED) ? DONE : BEAT1;
            BEAT1:   state_nx = !mem.mem_ready ? BEAT1 : a_cross ? BEAT2 : DONE;
            BEAT2:   state_nx = mem.mem_ready ? DONE : BEAT2;
            default: state_nx = IDLE;
        endcase
        beat = state == BEAT1 || state == BEAT2;
        hi_beat = state == BEAT2;
        stall = (state == IDLE && req) || beat;
        done = state == DONE;
        misaligned = state == DONE && a_mis;
        mem.mem_req = beat;
        mem.mem_we = beat && a_we;
        mem.mem_addr = beat ? {a_addr[31:2] + {29'd0, hi_beat}, 2'b00} : 32'h0;
        mem.mem_be = !beat ? 4'h0 : hi_beat ? be8[7:4] : be8[3:0];
        mem.mem_wdata = !beat ? 32'h0 : hi_beat ? wd64[63:32] : wd64[31:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_addr <= '0;
            a_wdata <= '0;
            a_n <= '0;
            a_sgn <= 1'b0;
            a_we <= 1'b0;
            a_mis <= 1'b0;
            lo <= '0;
            rdata <= '0;
        end else begin
            if (state == IDLE && req) begin
                a_addr <= addr;
                a_wdata <= wdata;
                a_n <= in_n;
                a_sgn <= in_sgn && !MemWrite;
                a_we <= MemWrite;
                a_mis <= in_cross && !ALLOW_MISALIGNED;
                if (in_cross && !ALLOW_MISALIGNED) rdata <= '0;
            end
            if (state == BEAT1 && mem.mem_ready) lo <= mem.mem_rdata;
            if (last && !a_we) rdata <= ext;
        end
    end
endmodule
